// File: rtl/bus_io_responder.sv
// bus_io_responder: toggle-bus I/O slave exposing GPIO out/in, a prescaled timer and an ID word.
// Optional feature: define BUS_IO_TIMER_EN to build the timer and its prescaler.
module bus_io_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned GPIO_W      = 10,
  parameter int unsigned PRESCALE    = 1000,
  parameter logic [15:0] ID_VALUE    = 16'h10A1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic [1:0]        cmd,
  input  logic              run,
  input  logic [15:0]       wr_data,
  output logic [15:0]       rd_data,
  output logic              done,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wcnt;
  logic [2:0]        lat_addr;
  logic [1:0]        lat_cmd;
  logic [DATA_W-1:0] lat_wdata;
  logic [GPIO_W-1:0] gpio_meta;
  logic [GPIO_W-1:0] gpio_sync;

  logic              pending;
  logic              acc_fire;
  logic [2:0]        acc_addr;
  logic [1:0]        acc_cmd;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] cur_val;
  logic [DATA_W-1:0] wr_val;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] timer_val;
  logic              unused_addr_hi;

  assign pending        = (run != done);
  assign unused_addr_hi = ^addr[15:3];

  // Access source: live bus inputs for zero-wait completion, latched request otherwise
  always_comb begin
    acc_fire  = 1'b0;
    acc_addr  = lat_addr;
    acc_cmd   = lat_cmd;
    acc_wdata = lat_wdata;
    if (state == S_IDLE) begin
      if (WAIT_STATES == 0) begin
        acc_fire  = pending;
        acc_addr  = addr[2:0];
        acc_cmd   = cmd;
        acc_wdata = wr_data;
      end
    end else if (wcnt == '0) begin
      acc_fire = 1'b1;
    end
  end

  // Register read mux, byte-lane write merge and read formatting
  always_comb begin
    case (acc_addr[2:1])
      2'd0:    cur_val = DATA_W'(gpio_out);
      2'd1:    cur_val = DATA_W'(gpio_sync);
      2'd2:    cur_val = timer_val;
      default: cur_val = ID_VALUE;
    endcase
    wr_val = cur_val;
    if (!acc_cmd[1]) begin
      wr_val = acc_wdata;
    end else if (acc_addr[0]) begin
      wr_val[15:8] = acc_wdata[7:0];
    end else begin
      wr_val[7:0] = acc_wdata[7:0];
    end
    if (!acc_cmd[1]) begin
      rd_val = cur_val;
    end else if (acc_addr[0]) begin
      rd_val = {8'h00, cur_val[15:8]};
    end else begin
      rd_val = {8'h00, cur_val[7:0]};
    end
  end

  // Request FSM, GPIO synchronizer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      lat_addr  <= '0;
      lat_cmd   <= '0;
      lat_wdata <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      gpio_out  <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      case (state)
        S_IDLE: begin
          if (pending && (WAIT_STATES != 0)) begin
            lat_addr  <= addr[2:0];
            lat_cmd   <= cmd;
            lat_wdata <= wr_data;
            wcnt      <= CNT_W'(WAIT_STATES - 1);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            state <= S_IDLE;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (acc_fire) begin
        done <= ~done;
        if (acc_cmd[0]) begin
          if (acc_addr[2:1] == 2'd0) begin
            gpio_out <= GPIO_W'(wr_val);
          end
        end else begin
          rd_data <= rd_val;
        end
      end
    end
  end

`ifdef BUS_IO_TIMER_EN
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] prescaler;
  logic              timer_wr;

  assign timer_wr  = acc_fire && acc_cmd[0] && (acc_addr[2:1] == 2'd2);
  assign timer_val = timer;

  // A CPU write beats a same-cycle increment and restarts the prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      prescaler <= '0;
    end else if (timer_wr) begin
      timer     <= wr_val;
      prescaler <= '0;
    end else if (prescaler == DATA_W'(PRESCALE - 1)) begin
      prescaler <= '0;
      timer     <= timer + 16'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end
`else
  assign timer_val = '0;
`endif

endmodule

// File: tb/tb_bus_io_responder.sv
// Table-driven bench for bus_io_responder: a 3-wait-state 10-bit-GPIO instance and a zero-wait 16-bit instance.
module tb_bus_io_responder;

  localparam int unsigned WS_A = 3;
  localparam int unsigned WS_B = 0;
  localparam logic [1:0] RW = 2'b00;
  localparam logic [1:0] WW = 2'b01;
  localparam logic [1:0] RB = 2'b10;
  localparam logic [1:0] WB = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [1:0]  cmd;
  logic [15:0] wr_data;
  logic [15:0] gpio_in;
  logic        run_a, run_b;
  logic        done_a, done_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [9:0]  gpio_out_a;
  logic [15:0] gpio_out_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          dut;
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_gpio;
    bit          scr;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] last_rd [2];
  logic [15:0] rd_v, go_v;

  bus_io_responder #(.WAIT_STATES(WS_A), .GPIO_W(10), .PRESCALE(4), .ID_VALUE(16'h10A1)) u_a (
    .clk(clk), .reset(reset), .addr(addr), .cmd(cmd), .run(run_a), .wr_data(wr_data),
    .rd_data(rd_data_a), .done(done_a), .gpio_in(gpio_in[9:0]), .gpio_out(gpio_out_a));

  bus_io_responder #(.WAIT_STATES(WS_B), .GPIO_W(16), .PRESCALE(4), .ID_VALUE(16'h10A1)) u_b (
    .clk(clk), .reset(reset), .addr(addr), .cmd(cmd), .run(run_b), .wr_data(wr_data),
    .rd_data(rd_data_b), .done(done_b), .gpio_in(gpio_in), .gpio_out(gpio_out_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 16'h%h, expected 16'h%h", name, act, exp);
    end
  endtask

  // One bus transaction; measures edges from first-visible posedge to the done toggle
  task automatic access(input int dut, input logic [1:0] c, input logic [15:0] a,
                        input logic [15:0] w, input bit scr, input string tag,
                        output logic [15:0] rd, output logic [15:0] go);
    logic d0;
    int   k;
    bit   seen;
    @(negedge clk);
    addr    = a;
    cmd     = c;
    wr_data = w;
    if (dut == 0) begin
      d0    = done_a;
      run_a = ~run_a;
    end else begin
      d0    = done_b;
      run_b = ~run_b;
    end
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk);
      #1;
      if (((dut == 0) ? done_a : done_b) != d0) begin
        seen = 1'b1;
      end else begin
        k++;
        if (scr) begin
          addr    = ~a;
          wr_data = ~w;
        end
      end
    end
    check({tag, "_latency"}, seen ? 16'(k) : 16'hFFFF, (dut == 0) ? 16'(WS_A) : 16'(WS_B));
    rd = (dut == 0) ? rd_data_a : rd_data_b;
    go = (dut == 0) ? 16'(gpio_out_a) : gpio_out_b;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    run_a   = 1'b0;
    run_b   = 1'b0;
    addr    = '0;
    cmd     = RW;
    wr_data = '0;
    gpio_in = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_rd_a", rd_data_a, 16'h0000);
    check("reset_done_a", 16'(done_a), 16'h0000);
    check("reset_gpio_a", 16'(gpio_out_a), 16'h0000);
    check("reset_rd_b", rd_data_b, 16'h0000);
    check("reset_done_b", 16'(done_b), 16'h0000);
    check("reset_gpio_b", gpio_out_b, 16'h0000);

    // Reset one clock into a 3-wait-state write abandons it
    @(negedge clk);
    addr    = 16'h0000;
    cmd     = WW;
    wr_data = 16'h03A5;
    run_a   = ~run_a;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midwait_reset_done", 16'(done_a), 16'h0000);
    check("midwait_reset_gpio", 16'(gpio_out_a), 16'h0000);

    gpio_in = 16'h0155;

    vecs.push_back('{0, WW, 16'h0000, 16'h03A5, 16'h0000, 16'h03A5, 1'b1});
    vecs.push_back('{0, RW, 16'h0000, 16'h0000, 16'h03A5, 16'h03A5, 1'b0});
    vecs.push_back('{0, RW, 16'h0001, 16'h0000, 16'h03A5, 16'h03A5, 1'b0});
    vecs.push_back('{0, RB, 16'h0001, 16'h0000, 16'h0003, 16'h03A5, 1'b0});
    vecs.push_back('{0, RB, 16'h0000, 16'h0000, 16'h00A5, 16'h03A5, 1'b0});
    vecs.push_back('{0, WW, 16'h0000, 16'h1234, 16'h0000, 16'h0234, 1'b0});
    vecs.push_back('{0, WB, 16'h0001, 16'h00FF, 16'h0000, 16'h0334, 1'b0});
    vecs.push_back('{0, RW, 16'h0000, 16'h0000, 16'h0334, 16'h0334, 1'b0});
    vecs.push_back('{1, WW, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{1, WB, 16'h0001, 16'h00FF, 16'h0000, 16'hFF34, 1'b0});
    vecs.push_back('{1, RW, 16'h0000, 16'h0000, 16'hFF34, 16'hFF34, 1'b0});
    vecs.push_back('{1, RB, 16'h0001, 16'h0000, 16'h00FF, 16'hFF34, 1'b0});
    vecs.push_back('{1, WB, 16'h0000, 16'h77AB, 16'h0000, 16'hFFAB, 1'b0});
    vecs.push_back('{1, RB, 16'h0000, 16'h0000, 16'h00AB, 16'hFFAB, 1'b0});
    vecs.push_back('{0, RW, 16'h0002, 16'h0000, 16'h0155, 16'h0334, 1'b0});
    vecs.push_back('{0, WW, 16'h0002, 16'hFFFF, 16'h0000, 16'h0334, 1'b0});
    vecs.push_back('{0, WW, 16'h0006, 16'hFFFF, 16'h0000, 16'h0334, 1'b0});
    vecs.push_back('{0, RW, 16'h0002, 16'h0000, 16'h0155, 16'h0334, 1'b0});
    vecs.push_back('{0, RW, 16'h0006, 16'h0000, 16'h10A1, 16'h0334, 1'b0});
    vecs.push_back('{0, RB, 16'h0007, 16'h0000, 16'h0010, 16'h0334, 1'b0});
    vecs.push_back('{0, RB, 16'h0006, 16'h0000, 16'h00A1, 16'h0334, 1'b0});
    vecs.push_back('{1, RW, 16'h0003, 16'h0000, 16'h0155, 16'hFFAB, 1'b0});
    vecs.push_back('{1, RW, 16'hFFFE, 16'h0000, 16'h10A1, 16'hFFAB, 1'b0});
    vecs.push_back('{1, RW, 16'h0008, 16'h0000, 16'hFFAB, 16'hFFAB, 1'b0});
    vecs.push_back('{1, WW, 16'h0006, 16'hFFFF, 16'h0000, 16'hFFAB, 1'b0});
    vecs.push_back('{1, RW, 16'h0006, 16'h0000, 16'h10A1, 16'hFFAB, 1'b0});

    foreach (vecs[i]) begin
      access(vecs[i].dut, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].scr,
             $sformatf("v%0d", i), rd_v, go_v);
      if (!vecs[i].cmd[0]) last_rd[vecs[i].dut] = vecs[i].exp_rd;
      check($sformatf("v%0d_rd", i), rd_v, last_rd[vecs[i].dut]);
      check($sformatf("v%0d_gpio", i), go_v, vecs[i].exp_gpio);
    end

`ifdef BUS_IO_TIMER_EN
    // Wrap from 16'hFFFE: increments land 4 and 8 edges after the write
    access(1, WW, 16'h0004, 16'hFFFE, 1'b0, "tmr_set", rd_v, go_v);
    repeat (8) @(posedge clk);
    access(1, RW, 16'h0004, 16'h0000, 1'b0, "tmr_wrap", rd_v, go_v);
    check("tmr_wrap_rd", rd_v, 16'h0000);

    // Word write on a prescaler-wrap edge
    access(1, WW, 16'h0004, 16'hFFFE, 1'b0, "tmr_set2", rd_v, go_v);
    repeat (3) @(posedge clk);
    access(1, WW, 16'h0004, 16'h1234, 1'b0, "tmr_wwin", rd_v, go_v);
    access(1, RW, 16'h0004, 16'h0000, 1'b0, "tmr_wwin_rd", rd_v, go_v);
    check("tmr_word_write_wins", rd_v, 16'h1234);

    // Byte write on a wrap edge keeps the pre-increment upper lane
    access(1, WW, 16'h0004, 16'h00FF, 1'b0, "tmr_set3", rd_v, go_v);
    repeat (3) @(posedge clk);
    access(1, WB, 16'h0004, 16'h0055, 1'b0, "tmr_bwin", rd_v, go_v);
    access(1, RW, 16'h0004, 16'h0000, 1'b0, "tmr_bwin_rd", rd_v, go_v);
    check("tmr_byte_write_wins", rd_v, 16'h0055);
`else
    access(0, RW, 16'h0004, 16'h0000, 1'b0, "notmr_rd0", rd_v, go_v);
    check("notmr_before", rd_v, 16'h0000);
    access(0, WW, 16'h0004, 16'h5555, 1'b0, "notmr_wr", rd_v, go_v);
    access(0, RW, 16'h0004, 16'h0000, 1'b0, "notmr_rd1", rd_v, go_v);
    check("notmr_after", rd_v, 16'h0000);
    access(1, WW, 16'h0004, 16'h5555, 1'b0, "notmr_wr_b", rd_v, go_v);
    access(1, RW, 16'h0005, 16'h0000, 1'b0, "notmr_rd_b", rd_v, go_v);
    check("notmr_after_b", rd_v, 16'h0000);
`endif

    // Synchronizer latency: new gpio_in value is not visible on the very next edge
    @(negedge clk);
    gpio_in = 16'h00AA;
    access(1, RW, 16'h0002, 16'h0000, 1'b0, "sync_early", rd_v, go_v);
    check("sync_early_rd", rd_v, 16'h0155);
    repeat (2) @(posedge clk);
    access(1, RW, 16'h0002, 16'h0000, 1'b0, "sync_late", rd_v, go_v);
    check("sync_late_rd", rd_v, 16'h00AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
